aes_decrypt_iter: RTL and testbench



---
 rtl/aes_decrypt_iter.sv | 253 +++++++++++++++++++++++++
 tb/tb_aes_decrypt_iter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_iter.sv
// aes_decrypt_iter: iterative AES-128 decryption, one inverse round per clock.
// Round keys are re-derived in reverse order from rk10, so no key array is kept.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   inValid / inReady     ciphertext + key handshake (inReady high only in IDLE)
//   inputData, key        128-bit ciphertext and cipher key, byte 0 at [127:120]
//   outValid / outReady   plaintext handshake, outValid held until accepted
//   outputData            128-bit registered plaintext
// Optional feature: define AES_KEY_CACHE_EN to cache the last key and its rk10,
// skipping KEY_EXPAND when the same key is presented again.
module aes_decrypt_iter #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inValid,
   output logic         inReady,
   input  logic [127:0] inputData,
   input  logic [127:0] key,
   output logic         outValid,
   input  logic         outReady,
   output logic [127:0] outputData
);

   localparam int unsigned CNT_W = 4;

   // Tables are stored with entry 0 in the top byte, so entry x sits at index ~x.
   localparam logic [255:0][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [255:0][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   typedef enum logic [2:0] {
      S_IDLE, S_KEY_EXPAND, S_INIT, S_ROUND, S_FINAL, S_DONE
   } fsm_t;

   // GF(2^8) multiply by 2, modulo 0x11b
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Inverse of xtime: undo the conditional 0x1b reduction, then shift back
   function automatic logic [7:0] inv_xtime(input logic [7:0] b);
      return b[0] ? ({1'b0, b[7:1]} ^ 8'h8d) : {1'b0, b[7:1]};
   endfunction

   // Multiply by a 4-bit constant (used for 0x09, 0x0b, 0x0d, 0x0e)
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
             (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[~w[31:24]], SBOX[~w[23:16]], SBOX[~w[15:8]], SBOX[~w[7:0]]};
   endfunction

   // Forward key schedule step: rk(i) -> rk(i+1)
   function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      n0 = k[127:96] ^ t;
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   // Reverse key schedule step: rk(i) -> rk(i-1)
   function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] p0, p1, p2, p3;
      p3 = k[31:0] ^ k[63:32];
      p2 = k[63:32] ^ k[95:64];
      p1 = k[95:64] ^ k[127:96];
      p0 = k[127:96] ^ sub_word({p3[23:0], p3[31:24]}) ^ {rc, 24'h0};
      return {p0, p1, p2, p3};
   endfunction

   // InvShiftRows then InvSubBytes; byte b is row b%4, column b/4
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      int src;
      o = '0;
      for (int b = 0; b < 16; b++) begin
         src = (b % 4) + 4 * (((b / 4) - (b % 4) + 4) % 4);
         o[127 - 8*b -: 8] = INV_SBOX[~s[127 - 8*src -: 8]];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
         o[119 - 32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
         o[111 - 32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
         o[103 - 32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
      end
      return o;
   endfunction

   fsm_t              fsm_q, fsm_next;
   logic [127:0]      data_q, key_q;
   logic [7:0]        rcon_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              cnt_last;
   logic              cache_hit;
   logic              load_en, expand_en, init_en, round_en, final_en;
   logic [127:0]      rk_fwd, rk_prev, shifted, round_out;

   assign cnt_last  = (cnt_q == CNT_W'(1));
   assign rk_fwd    = fwd_key(key_q, rcon_q);
   assign rk_prev   = prev_key(key_q, rcon_q);
   assign shifted   = inv_shift_sub(data_q);
   assign round_out = inv_mix(shifted ^ rk_prev);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) fsm_q <= S_IDLE;
      else          fsm_q <= fsm_next;
   end

   // Next-state logic
   always_comb begin
      fsm_next = fsm_q;
      case (fsm_q)
         S_IDLE:       if (inValid) fsm_next = cache_hit ? S_INIT : S_KEY_EXPAND;
         S_KEY_EXPAND: if (cnt_last) fsm_next = S_INIT;
         S_INIT:       fsm_next = S_ROUND;
         S_ROUND:      if (cnt_last) fsm_next = S_FINAL;
         S_FINAL:      fsm_next = S_DONE;
         S_DONE:       if (outReady) fsm_next = S_IDLE;
         default:      fsm_next = S_IDLE;
      endcase
   end

   // Datapath control decode
   always_comb begin
      load_en   = 1'b0;
      expand_en = 1'b0;
      init_en   = 1'b0;
      round_en  = 1'b0;
      final_en  = 1'b0;
      case (fsm_q)
         S_IDLE:       load_en   = inValid;
         S_KEY_EXPAND: expand_en = 1'b1;
         S_INIT:       init_en   = 1'b1;
         S_ROUND:      round_en  = 1'b1;
         S_FINAL:      final_en  = 1'b1;
         default:      ;
      endcase
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q     <= '0;
         key_q      <= '0;
         rcon_q     <= '0;
         cnt_q      <= '0;
         outputData <= '0;
         outValid   <= 1'b0;
         inReady    <= 1'b1;
      end else begin
         outValid <= (fsm_next == S_DONE);
         inReady  <= (fsm_next == S_IDLE);
         if (load_en) begin
            data_q <= inputData;
            key_q  <= key;
            rcon_q <= 8'h01;
            cnt_q  <= CNT_W'(NUM_ROUNDS);
`ifdef AES_KEY_CACHE_EN
            if (cache_hit) begin
               key_q  <= cache_rk10_q;
               rcon_q <= 8'h36;
            end
`endif
         end
         if (expand_en) begin
            key_q <= rk_fwd;
            cnt_q <= cnt_q - CNT_W'(1);
            // rcon stays at 0x36 after the last step so the reverse walk starts there
            if (!cnt_last) rcon_q <= xtime(rcon_q);
         end
         if (init_en) begin
            data_q <= data_q ^ key_q;
            cnt_q  <= CNT_W'(NUM_ROUNDS - 1);
         end
         if (round_en) begin
            key_q  <= rk_prev;
            rcon_q <= inv_xtime(rcon_q);
            data_q <= round_out;
            cnt_q  <= cnt_q - CNT_W'(1);
         end
         if (final_en) begin
            key_q      <= rk_prev;
            outputData <= shifted ^ rk_prev;
         end
      end
   end

`ifdef AES_KEY_CACHE_EN
   logic         cache_valid_q;
   logic [127:0] cache_key_q, cache_rk10_q;

   assign cache_hit = cache_valid_q && (key == cache_key_q);

   // Key cache: key captured on a miss, rk10 captured when expansion completes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cache_valid_q <= 1'b0;
         cache_key_q   <= '0;
         cache_rk10_q  <= '0;
      end else begin
         if (load_en && !cache_hit) begin
            cache_key_q   <= key;
            cache_valid_q <= 1'b0;
         end
         if (expand_en && cnt_last) begin
            cache_rk10_q  <= rk_fwd;
            cache_valid_q <= 1'b1;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Self-checking bench for aes_decrypt_iter: FIPS-197 vectors, latency,
// backpressure, mid-block reset and back-to-back operation.
module tb_aes_decrypt_iter;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] key_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   aes_decrypt_iter #(.NUM_ROUNDS(10)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .inValid    (in_valid),
      .inReady    (in_ready),
      .inputData  (in_data),
      .key        (key_in),
      .outValid   (out_valid),
      .outReady   (out_ready),
      .outputData (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
   } vec_t;

   typedef struct {
      logic [127:0] pt;
      int           lat;
      int           acc;
   } exp_t;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   int           last_lat = 0;
   exp_t         sb_q[$];
   logic         m_valid = 1'b0;
   logic [127:0] m_key = '0;
   vec_t         vecs[3];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Expected latency from a model of the optional key cache
   task automatic note_accept(input logic [127:0] k, input logic [127:0] pt);
      exp_t e;
      logic hit;
      hit = 1'b0;
`ifdef AES_KEY_CACHE_EN
      hit = m_valid && (k == m_key);
`endif
      if (!hit) begin
         m_key   = k;
         m_valid = 1'b1;
      end
      e.pt = pt;
      e.lat = hit ? 11 : 21;
      e.acc = cyc;
      last_lat = e.lat;
      sb_q.push_back(e);
   endtask

   task automatic send(input logic [127:0] k, input logic [127:0] ct, input logic [127:0] pt);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      key_in   = k;
      in_data  = ct;
      in_valid = 1'b1;
      tick();
      note_accept(k, pt);
      in_valid = 1'b0;
      check("in_ready_drop", 128'(in_ready), 128'(0));
   endtask

   task automatic wait_out();
      int n;
      n = 0;
      while (!out_valid && n < 200) begin
         tick();
         n++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("FAIL out_valid_timeout: got 0 expected 1");
      end
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_unexpected: got output %h expected none", tag, out_data);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_data"}, out_data, e.pt);
         check({tag, "_latency"}, 128'(cyc - e.acc), 128'(e.lat));
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      int   n, nacc, nout, a1, a2, lat1;
      logic seen;
      logic [127:0] cur_pt;

      vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
      vecs[1] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
      vecs[2] = '{key: B_KEY,  ct: B_CT,  pt: B_PT};

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      key_in    = '0;
      out_ready = 1'b0;
      #12;
      check("reset_in_ready", 128'(in_ready), 128'(1));
      check("reset_out_valid", 128'(out_valid), 128'(0));
      check("reset_out_data", out_data, 128'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Table-driven vectors: C.1, C.1 again (cache hit if enabled), then B
      for (int i = 0; i < 3; i++) begin
         send(vecs[i].key, vecs[i].ct, vecs[i].pt);
         wait_out();
         check_out($sformatf("vec%0d", i));
         release_out();
      end

      // Backpressure: output held 30 cycles, new inValid ignored meanwhile
      send(C1_KEY, C1_CT, C1_PT);
      wait_out();
      check_out("bp");
      key_in   = B_KEY;
      in_data  = B_CT;
      in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick();
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_out_data", out_data, C1_PT);
         check("bp_in_ready", 128'(in_ready), 128'(0));
      end
      in_valid = 1'b0;
      release_out();
      check("bp_idle_in_ready", 128'(in_ready), 128'(1));
      check("bp_done_cleared", 128'(out_valid), 128'(0));
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      check("bp_no_extra_block", 128'(seen), 128'(0));

      // Reset mid-block at cycle 15 after acceptance
      send(C1_KEY, C1_CT, C1_PT);
      while (cyc < sb_q[0].acc + 15) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_out_data", out_data, 128'h0);
      check("rst_in_ready", 128'(in_ready), 128'(1));
      sb_q.delete();
      m_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      send(C1_KEY, C1_CT, C1_PT);
      wait_out();
      check_out("rst_rerun");
      release_out();

      // Back-to-back with outReady tied high: C.1 then B
      out_ready = 1'b1;
      key_in    = C1_KEY;
      in_data   = C1_CT;
      cur_pt    = C1_PT;
      in_valid  = 1'b1;
      nacc = 0; nout = 0; a1 = 0; a2 = 0; lat1 = 0; n = 0;
      while (nout < 2 && n < 300) begin
         seen = in_valid && in_ready;
         tick();
         n++;
         if (seen) begin
            note_accept(key_in, cur_pt);
            if (nacc == 0) begin
               a1      = cyc;
               lat1    = last_lat;
               key_in  = B_KEY;
               in_data = B_CT;
               cur_pt  = B_PT;
            end else begin
               a2       = cyc;
               in_valid = 1'b0;
            end
            nacc++;
         end
         if (out_valid) begin
            check_out("b2b");
            nout++;
         end
      end
      if (nout < 2) begin
         checks++;
         errors++;
         $display("FAIL b2b_timeout: got %0d outputs expected 2", nout);
      end
      check("b2b_spacing", 128'(a2 - a1), 128'(lat1 + 2));
      out_ready = 1'b0;
      in_valid  = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
